// File: rtl/drc_pkt_assembler.sv
// rtl/drc_pkt_assembler.sv - DRC packet assembler: arbitrated sources into one registered packet slot
//
// Arbitrates among NUM_SRC request/response sources (0 = unreachable rsp,
// 1 = upload rsp, 2 = download rsp, 3 = refresh req) and registers the
// winner into a single output packet slot with valid/ready back-pressure.
//
// Optional feature: define DRC_PKT_ASS_RR_EN for round-robin arbitration.
// Without it, arbitration is fixed priority (lowest index wins) and there is
// no pointer register.
//
// Ports:
//   iClk, iResetN   clock; asynchronous active-low reset
//   iSrcVld         per-source valid
//   oSrcRdy         per-source accept, one-hot or zero, combinational
//   iSrcType/Addr/Port/Data  packed per-source fields, source i at [i*W +: W]
//   oPktVld/iPktRdy output slot handshake
//   oPktType/oPktSrcAddr/oPktTargtPort/oPktData  registered packet fields
//   oPktSrcId       index of the source that produced the held packet
//   oPktCnt         saturating count of delivered packets
module drc_pkt_assembler #(
  parameter int NUM_SRC = 4,
  parameter int TYPE_W  = 6,
  parameter int ADDR_W  = 16,
  parameter int PORT_W  = 5,
  parameter int DATA_W  = 128,
  localparam int SID_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      iClk,
  input  logic                      iResetN,
  input  logic [NUM_SRC-1:0]        iSrcVld,
  output logic [NUM_SRC-1:0]        oSrcRdy,
  input  logic [NUM_SRC*TYPE_W-1:0] iSrcType,
  input  logic [NUM_SRC*ADDR_W-1:0] iSrcAddr,
  input  logic [NUM_SRC*PORT_W-1:0] iSrcPort,
  input  logic [NUM_SRC*DATA_W-1:0] iSrcData,
  output logic                      oPktVld,
  input  logic                      iPktRdy,
  output logic [TYPE_W-1:0]         oPktType,
  output logic [ADDR_W-1:0]         oPktSrcAddr,
  output logic [PORT_W-1:0]         oPktTargtPort,
  output logic [DATA_W-1:0]         oPktData,
  output logic [SID_W-1:0]          oPktSrcId,
  output logic [15:0]               oPktCnt
);

  // Slot can take a new packet when it is empty or being drained this cycle.
  logic             load;
  logic             grantHit;
  logic [SID_W-1:0] grantIdx;
  logic             xfer;

  logic [TYPE_W-1:0] selType;
  logic [ADDR_W-1:0] selAddr;
  logic [PORT_W-1:0] selPort;
  logic [DATA_W-1:0] selData;

  assign load = ~oPktVld | iPktRdy;
  assign xfer = load & grantHit;

`ifdef DRC_PKT_ASS_RR_EN
  // rPtr names the highest-priority source; search climbs and wraps.
  logic [SID_W-1:0] rPtr;
  logic [SID_W-1:0] cand;

  function automatic logic [SID_W-1:0] wrapIdx(input int base, input int offs);
    int sum;
    sum = base + offs;
    if (sum >= NUM_SRC) sum = sum - NUM_SRC;
    return SID_W'(sum);
  endfunction

  always_comb begin
    grantHit = 1'b0;
    grantIdx = '0;
    cand     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = wrapIdx(int'(rPtr), k);
      if (!grantHit && iSrcVld[cand]) begin
        grantHit = 1'b1;
        grantIdx = cand;
      end
    end
  end

  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) begin
      rPtr <= '0;
    end else if (xfer) begin
      rPtr <= wrapIdx(int'(grantIdx), 1);
    end
  end
`else
  always_comb begin
    grantHit = 1'b0;
    grantIdx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!grantHit && iSrcVld[k]) begin
        grantHit = 1'b1;
        grantIdx = SID_W'(k);
      end
    end
  end
`endif

  // Field mux for the granted source.
  always_comb begin
    selType = '0;
    selAddr = '0;
    selPort = '0;
    selData = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (SID_W'(k) == grantIdx) begin
        selType = iSrcType[k*TYPE_W +: TYPE_W];
        selAddr = iSrcAddr[k*ADDR_W +: ADDR_W];
        selPort = iSrcPort[k*PORT_W +: PORT_W];
        selData = iSrcData[k*DATA_W +: DATA_W];
      end
    end
  end

  // Accept is gated by reset so a source never sees a handshake that the
  // (held-in-reset) slot would not capture.
  always_comb begin
    oSrcRdy = '0;
    if (iResetN && xfer) oSrcRdy[grantIdx] = 1'b1;
  end

  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) begin
      oPktVld       <= 1'b0;
      oPktType      <= '0;
      oPktSrcAddr   <= '0;
      oPktTargtPort <= '0;
      oPktData      <= '0;
      oPktSrcId     <= '0;
    end else if (load) begin
      // Empty load drops valid but keeps the last fields visible.
      oPktVld <= grantHit;
      if (grantHit) begin
        oPktType      <= selType;
        oPktSrcAddr   <= selAddr;
        oPktTargtPort <= selPort;
        oPktData      <= selData;
        oPktSrcId     <= grantIdx;
      end
    end
  end

  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) begin
      oPktCnt <= 16'd0;
    end else if (oPktVld && iPktRdy && (oPktCnt != 16'hFFFF)) begin
      oPktCnt <= oPktCnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_drc_pkt_assembler.sv
// tb/tb_drc_pkt_assembler.sv - self-checking bench for drc_pkt_assembler
module tb_drc_pkt_assembler;

`ifdef DRC_PKT_ASS_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam int N = 4;

  logic          iClk = 1'b0;
  logic          iResetN;
  logic [3:0]    iSrcVld;
  logic [3:0]    oSrcRdy;
  logic [23:0]   iSrcType;
  logic [63:0]   iSrcAddr;
  logic [19:0]   iSrcPort;
  logic [511:0]  iSrcData;
  logic          oPktVld;
  logic          iPktRdy;
  logic [5:0]    oPktType;
  logic [15:0]   oPktSrcAddr;
  logic [4:0]    oPktTargtPort;
  logic [127:0]  oPktData;
  logic [1:0]    oPktSrcId;
  logic [15:0]   oPktCnt;

  drc_pkt_assembler dut (
    .iClk(iClk), .iResetN(iResetN),
    .iSrcVld(iSrcVld), .oSrcRdy(oSrcRdy),
    .iSrcType(iSrcType), .iSrcAddr(iSrcAddr), .iSrcPort(iSrcPort), .iSrcData(iSrcData),
    .oPktVld(oPktVld), .iPktRdy(iPktRdy),
    .oPktType(oPktType), .oPktSrcAddr(oPktSrcAddr), .oPktTargtPort(oPktTargtPort),
    .oPktData(oPktData), .oPktSrcId(oPktSrcId), .oPktCnt(oPktCnt)
  );

  always #5 iClk = ~iClk;

  int nCmp = 0;
  int nFail = 0;

  // Source-side state driven onto the DUT.
  logic [3:0]   sVld;
  logic [5:0]   sType [N];
  logic [15:0]  sAddr [N];
  logic [4:0]   sPort [N];
  logic [127:0] sData [N];

  // Reference model of the output slot.
  bit           mVld;
  logic [5:0]   mType;
  logic [15:0]  mAddr;
  logic [4:0]   mPort;
  logic [127:0] mData;
  int           mSid;
  int           mCnt;
  int           mPtr;
  int           lastAcc;

  typedef struct {
    logic [3:0]  vld;
    logic        rdy;
    logic [3:0]  eRdy;
    logic        eVld;
    logic [1:0]  eSid;
    logic [5:0]  eType;
    logic [15:0] eCnt;
  } vec_t;
  vec_t tab [17];

  function automatic vec_t mk(logic [3:0] v, logic r, logic [3:0] er, logic ev,
                              logic [1:0] es, logic [5:0] et, logic [15:0] ec);
    vec_t x;
    x.vld = v; x.rdy = r; x.eRdy = er; x.eVld = ev; x.eSid = es; x.eType = et; x.eCnt = ec;
    return x;
  endfunction

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    iSrcVld = sVld;
    for (int i = 0; i < N; i++) begin
      iSrcType[i*6 +: 6]     = sType[i];
      iSrcAddr[i*16 +: 16]   = sAddr[i];
      iSrcPort[i*5 +: 5]     = sPort[i];
      iSrcData[i*128 +: 128] = sData[i];
    end
  endtask

  task automatic model_reset();
    mVld = 0; mType = '0; mAddr = '0; mPort = '0; mData = '0;
    mSid = 0; mCnt = 0; mPtr = 0; lastAcc = -1;
  endtask

  // Winner under the arbitration rule: first valid source starting at the
  // priority base and wrapping around.
  function automatic int pick();
    int base;
    base = RR ? mPtr : 0;
    for (int k = 0; k < N; k++) begin
      if (sVld[(base + k) % N]) return (base + k) % N;
    end
    return -1;
  endfunction

  task automatic model_check();
    int w;
    bit ld;
    logic [3:0] er;
    w = pick();
    ld = !mVld || iPktRdy;
    er = '0;
    if (ld && w >= 0) er[w] = 1'b1;
    cmp("srcRdy", oSrcRdy, er);
    cmp("pktVld", oPktVld, mVld);
    cmp("pktType", oPktType, mType);
    cmp("pktAddr", oPktSrcAddr, mAddr);
    cmp("pktPort", oPktTargtPort, mPort);
    cmp("pktData", oPktData, mData);
    cmp("pktSid", oPktSrcId, mSid[1:0]);
    cmp("pktCnt", oPktCnt, mCnt[15:0]);
  endtask

  // Apply one clock edge to the model, then move to the next negedge.
  task automatic advance();
    int w;
    bit ld;
    w = pick();
    ld = !mVld || iPktRdy;
    lastAcc = -1;
    if (mVld && iPktRdy && mCnt < 65535) mCnt++;
    if (ld) begin
      if (w >= 0) begin
        mVld = 1; mType = sType[w]; mAddr = sAddr[w]; mPort = sPort[w];
        mData = sData[w]; mSid = w; mPtr = (w + 1) % N; lastAcc = w;
      end else begin
        mVld = 0;
      end
    end
    @(posedge iClk);
    @(negedge iClk);
  endtask

  task automatic new_fields(input int i);
    sType[i] = 6'($urandom);
    sAddr[i] = 16'($urandom);
    sPort[i] = 5'($urandom);
    sData[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tab[0]  = mk(4'b0001, 1, 4'b0001, 0, 0, 6'h00, 0);
    tab[1]  = mk(4'b0000, 1, 4'b0000, 1, 0, 6'h06, 0);
    tab[2]  = mk(4'b0000, 1, 4'b0000, 0, 0, 6'h06, 1);
    tab[3]  = mk(4'b1110, 1, 4'b0010, 0, 0, 6'h06, 1);
    tab[4]  = mk(4'b1110, 1, RR ? 4'b0100 : 4'b0010, 1, 1, 6'h11, 1);
    tab[5]  = mk(4'b1110, 1, RR ? 4'b1000 : 4'b0010, 1, RR ? 2'd2 : 2'd1, RR ? 6'h22 : 6'h11, 2);
    tab[6]  = mk(4'b1110, 1, 4'b0010, 1, RR ? 2'd3 : 2'd1, RR ? 6'h33 : 6'h11, 3);
    tab[7]  = mk(4'b0000, 1, 4'b0000, 1, 1, 6'h11, 4);
    tab[8]  = mk(4'b0000, 0, 4'b0000, 0, 1, 6'h11, 5);
    tab[9]  = mk(4'b0100, 0, 4'b0100, 0, 1, 6'h11, 5);
    tab[10] = mk(4'b0100, 0, 4'b0000, 1, 2, 6'h22, 5);
    tab[11] = mk(4'b0100, 0, 4'b0000, 1, 2, 6'h22, 5);
    tab[12] = mk(4'b0100, 0, 4'b0000, 1, 2, 6'h22, 5);
    tab[13] = mk(4'b0100, 0, 4'b0000, 1, 2, 6'h22, 5);
    tab[14] = mk(4'b0100, 1, 4'b0100, 1, 2, 6'h22, 5);
    tab[15] = mk(4'b0000, 1, 4'b0000, 1, 2, 6'h22, 6);
    tab[16] = mk(4'b0000, 1, 4'b0000, 0, 2, 6'h22, 7);

    sType[0] = 6'h06; sType[1] = 6'h11; sType[2] = 6'h22; sType[3] = 6'h33;
    sAddr[0] = 16'h1234; sAddr[1] = 16'h2222; sAddr[2] = 16'h3333; sAddr[3] = 16'h4444;
    sPort[0] = 5'd3; sPort[1] = 5'd7; sPort[2] = 5'd12; sPort[3] = 5'd31;
    for (int i = 0; i < N; i++) sData[i] = {4{8'hA0 + 8'(i), 24'h5A5A5A}};

    // Reset state, with every source requesting.
    iResetN = 1'b0;
    iPktRdy = 1'b1;
    sVld = 4'b1111;
    drive();
    model_reset();
    repeat (2) @(negedge iClk);
    #1;
    cmp("rst_srcRdy", oSrcRdy, 4'b0000);
    cmp("rst_vld", oPktVld, 1'b0);
    cmp("rst_type", oPktType, 6'h00);
    cmp("rst_addr", oPktSrcAddr, 16'h0000);
    cmp("rst_port", oPktTargtPort, 5'd0);
    cmp("rst_data", oPktData, 128'h0);
    cmp("rst_sid", oPktSrcId, 2'd0);
    cmp("rst_cnt", oPktCnt, 16'd0);
    @(negedge iClk);
    iResetN = 1'b1;

    // Directed table: single source, contention, back-pressure, no-bubble refill.
    for (int r = 0; r < 17; r++) begin
      sVld = tab[r].vld;
      iPktRdy = tab[r].rdy;
      drive();
      #1;
      cmp($sformatf("tab%0d_srcRdy", r), oSrcRdy, tab[r].eRdy);
      cmp($sformatf("tab%0d_vld", r), oPktVld, tab[r].eVld);
      cmp($sformatf("tab%0d_sid", r), oPktSrcId, tab[r].eSid);
      cmp($sformatf("tab%0d_type", r), oPktType, tab[r].eType);
      cmp($sformatf("tab%0d_addr", r), oPktSrcAddr, (r == 0) ? 16'h0 : sAddr[tab[r].eSid]);
      cmp($sformatf("tab%0d_port", r), oPktTargtPort, (r == 0) ? 5'd0 : sPort[tab[r].eSid]);
      cmp($sformatf("tab%0d_cnt", r), oPktCnt, tab[r].eCnt);
      advance();
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (lastAcc == i || !sVld[i]) begin
          sVld[i] = ($urandom_range(0, 99) < 55);
          if (sVld[i]) new_fields(i);
        end
      end
      iPktRdy = ($urandom_range(0, 99) < 70);
      drive();
      #1;
      model_check();
      advance();
    end

    // Asynchronous reset while a packet is held under back-pressure.
    sVld = 4'b0001;
    iPktRdy = 1'b1;
    drive();
    #1;
    model_check();
    advance();
    sVld = 4'b1111;
    iPktRdy = 1'b0;
    drive();
    #1;
    model_check();
    #2;
    iResetN = 1'b0;
    #1;
    cmp("arst_vld", oPktVld, 1'b0);
    cmp("arst_srcRdy", oSrcRdy, 4'b0000);
    cmp("arst_cnt", oPktCnt, 16'd0);
    model_reset();
    @(posedge iClk);
    @(negedge iClk);
    iResetN = 1'b1;
    iPktRdy = 1'b1;
    drive();
    #1;
    cmp("post_rst_srcRdy", oSrcRdy, 4'b0001);
    model_check();
    advance();
    #1;
    cmp("post_rst_vld", oPktVld, 1'b1);
    cmp("post_rst_sid", oPktSrcId, 2'd0);
    model_check();

    // Counter saturation: continuous delivery from source 0.
    sVld = 4'b0001;
    iPktRdy = 1'b1;
    drive();
    for (int n = 0; n < 70000 && mCnt < 65534; n++) advance();
    #1;
    cmp("sat_preload", oPktCnt, 16'hFFFE);
    repeat (3) advance();
    #1;
    cmp("sat_reach", oPktCnt, 16'hFFFF);
    repeat (2) advance();
    #1;
    cmp("sat_hold", oPktCnt, 16'hFFFF);
    model_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
